gnn_result_collector: RTL

Downstream consumer of gnn_top. Captures the eight layer-2 results (out0/out1 for nodes 0..3) as their per-output ready flags assert, and classifies each node by signed argmax of out0 vs out1. Streams one 24-bit record per node over a valid/ready interface to the host/readout logic. Times out partial frames and resynchronises on in_ready.

---
 rtl/gnn_result_collector.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/gnn_result_collector.sv
`default_nettype none
// ============================================================================
// gnn_result_collector: captures gnn_top layer-2 scores, argmax-classifies
// each node and streams one record per node. Optional: GNN_COLLECT_HIST_EN.
// Revision: 1.0
// ============================================================================
module gnn_result_collector #(
    parameter int DATA_W      = 21,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_ready,
    input  logic [DATA_W-1:0] out0_node0,
    input  logic [DATA_W-1:0] out0_node1,
    input  logic [DATA_W-1:0] out0_node2,
    input  logic [DATA_W-1:0] out0_node3,
    input  logic [DATA_W-1:0] out1_node0,
    input  logic [DATA_W-1:0] out1_node1,
    input  logic [DATA_W-1:0] out1_node2,
    input  logic [DATA_W-1:0] out1_node3,
    input  logic              out10_ready_node0,
    input  logic              out10_ready_node1,
    input  logic              out10_ready_node2,
    input  logic              out10_ready_node3,
    input  logic              out11_ready_node0,
    input  logic              out11_ready_node1,
    input  logic              out11_ready_node2,
    input  logic              out11_ready_node3,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [23:0]       res_data,
    output logic              frame_done,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  hist_cls0,
    output logic [CNT_W-1:0]  hist_cls1
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_STREAM  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] in0 [4];
    logic [DATA_W-1:0] in1 [4];
    logic [3:0]        flag0, flag1;
    logic [DATA_W-1:0] cap0_q [4];
    logic [DATA_W-1:0] cap0_d [4];
    logic [DATA_W-1:0] cap1_q [4];
    logic [DATA_W-1:0] cap1_d [4];
    logic [3:0]        sticky0_q, sticky0_d, sticky1_q, sticky1_d;
    logic [1:0]        node_q, node_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic              frame_done_q, frame_done_d;
    logic              err_timeout_q, err_timeout_d;
    logic [3:0]        cls;
    logic [DATA_W-1:0] score [4];
    logic              xfer;

    assign in0[0] = out0_node0;
    assign in0[1] = out0_node1;
    assign in0[2] = out0_node2;
    assign in0[3] = out0_node3;
    assign in1[0] = out1_node0;
    assign in1[1] = out1_node1;
    assign in1[2] = out1_node2;
    assign in1[3] = out1_node3;
    assign flag0  = {out10_ready_node3, out10_ready_node2, out10_ready_node1, out10_ready_node0};
    assign flag1  = {out11_ready_node3, out11_ready_node2, out11_ready_node1, out11_ready_node0};

    // Ties resolve to class 0.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cls[i]   = $signed(cap1_q[i]) > $signed(cap0_q[i]);
            score[i] = cls[i] ? cap1_q[i] : cap0_q[i];
        end
    end

    assign res_valid   = (state_q == ST_STREAM);
    assign xfer        = res_valid && res_ready;
    assign res_data    = res_valid ? {node_q, cls[node_q], score[node_q]} : '0;
    assign frame_done  = frame_done_q;
    assign err_timeout = err_timeout_q;

    always_comb begin
        state_d       = state_q;
        cap0_d        = cap0_q;
        cap1_d        = cap1_q;
        sticky0_d     = sticky0_q;
        sticky1_d     = sticky1_q;
        node_d        = node_q;
        tcnt_d        = tcnt_q;
        frame_done_d  = 1'b0;
        err_timeout_d = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (&{sticky1_q, sticky0_q}) begin
                    state_d = ST_STREAM;
                    node_d  = 2'd0;
                    tcnt_d  = '0;
                end else if (!in_ready) begin
                    sticky0_d = '0;
                    sticky1_d = '0;
                    tcnt_d    = '0;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (flag0[i] && !sticky0_q[i]) begin
                            cap0_d[i]    = in0[i];
                            sticky0_d[i] = 1'b1;
                        end
                        if (flag1[i] && !sticky1_q[i]) begin
                            cap1_d[i]    = in1[i];
                            sticky1_d[i] = 1'b1;
                        end
                    end
                    // The counter runs from the cycle after the first capture.
                    if ((|{sticky1_q, sticky0_q}) && !(&{sticky1_d, sticky0_d})) begin
                        if (tcnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                            sticky0_d     = '0;
                            sticky1_d     = '0;
                            tcnt_d        = '0;
                            err_timeout_d = 1'b1;
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_STREAM: begin
                if (res_ready) begin
                    if (node_q == 2'd3) begin
                        state_d      = ST_COLLECT;
                        sticky0_d    = '0;
                        sticky1_d    = '0;
                        node_d       = 2'd0;
                        frame_done_d = 1'b1;
                    end else begin
                        node_d = node_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_COLLECT;
            cap0_q        <= '{default: '0};
            cap1_q        <= '{default: '0};
            sticky0_q     <= '0;
            sticky1_q     <= '0;
            node_q        <= '0;
            tcnt_q        <= '0;
            frame_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cap0_q        <= cap0_d;
            cap1_q        <= cap1_d;
            sticky0_q     <= sticky0_d;
            sticky1_q     <= sticky1_d;
            node_q        <= node_d;
            tcnt_q        <= tcnt_d;
            frame_done_q  <= frame_done_d;
            err_timeout_q <= err_timeout_d;
        end
    end

`ifdef GNN_COLLECT_HIST_EN
    logic [CNT_W-1:0] hist0_q, hist0_d, hist1_q, hist1_d;

    always_comb begin
        hist0_d = hist0_q;
        hist1_d = hist1_q;
        if (xfer) begin
            if (cls[node_q]) begin
                if (!(&hist1_q)) hist1_d = hist1_q + 1'b1;
            end else begin
                if (!(&hist0_q)) hist0_d = hist0_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist0_q <= '0;
            hist1_q <= '0;
        end else begin
            hist0_q <= hist0_d;
            hist1_q <= hist1_d;
        end
    end

    assign hist_cls0 = hist0_q;
    assign hist_cls1 = hist1_q;
`else
    assign hist_cls0 = '0;
    assign hist_cls1 = '0;
`endif

endmodule
`default_nettype wire
